// File: rtl/piezo_dur_cnt.sv
// Note-duration counter for a piezo tone sequencer.
// Counts enabled clock ticks and flags the cycle whose elapsed count equals
// the requested note duration.
module piezo_dur_cnt (
  input  logic       clk,
  input  logic       rst_n,     // active-high asynchronous reset despite the suffix
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] note_dur,
  output logic       note_over
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] dur_cnt;

  // Elapsed-tick counter: clear beats enable, wraps modulo 256, never stops at the target
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dur_cnt <= '0;
    end else if (clr) begin
      dur_cnt <= '0;
    end else if (en) begin
      dur_cnt <= dur_cnt + CNT_W'(1);
    end
  end

  // Match flag is purely combinational so a new target is visible without a clock edge
  assign note_over = (dur_cnt == note_dur);

endmodule

// File: tb/tb_piezo_dur_cnt.sv
// Self-checking bench for piezo_dur_cnt: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_piezo_dur_cnt;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       en;
  logic [7:0] note_dur;
  logic       note_over;

  int n_chk;
  int n_fail;
  int model_cnt;   // elapsed ticks as a plain integer, kept in 0..255

  typedef struct {
    logic       clr;
    logic       en;
    logic [7:0] dur;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  piezo_dur_cnt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .note_dur  (note_dur),
    .note_over (note_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: note_over=%b expected=%b at t=%0t", name, got, exp, $time);
    end
  endtask

  // Append n identical edges; all but the last expect exp_mid
  function automatic void add(input logic c, input logic e, input logic [7:0] d,
                              input int n, input logic exp_mid, input logic exp_last);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.clr = c;
      v.en  = e;
      v.dur = d;
      v.exp = (i == n - 1) ? exp_last : exp_mid;
      vecs.push_back(v);
    end
  endfunction

  // Behavioural reference: one rising edge with the current inputs
  function automatic void model_edge();
    if (rst_n)     model_cnt = 0;
    else if (clr)  model_cnt = 0;
    else if (en)   model_cnt = (model_cnt + 1) % 256;
  endfunction

  function automatic logic model_over();
    return (model_cnt == int'(note_dur));
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    model_cnt = 0;

    // Directed table: 8-tick note, clear, hold, long note up to 255 and wrap
    add(1'b0, 1'b1, 8'd8,  8,   1'b0, 1'b1);   // 8 edges from 0 reach the target
    add(1'b1, 1'b0, 8'd1,  1,   1'b0, 1'b0);   // clear with new target 1
    add(1'b0, 1'b1, 8'd1,  1,   1'b0, 1'b1);   // one edge -> count 1
    add(1'b0, 1'b0, 8'd6,  3,   1'b0, 1'b0);   // hold at 1
    add(1'b0, 1'b1, 8'd6,  5,   1'b0, 1'b1);   // 2..6
    add(1'b0, 1'b1, 8'hFF, 249, 1'b0, 1'b1);   // 7..255
    add(1'b0, 1'b1, 8'hFF, 1,   1'b0, 1'b0);   // wrap to 0
    add(1'b0, 1'b1, 8'hFF, 1,   1'b0, 1'b0);   // 1: no auto-stop after wrap

    // Reset held with target 8 and enable high
    rst_n    = 1'b1;
    clr      = 1'b0;
    en       = 1'b1;
    note_dur = 8'd8;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dur8", note_over, 1'b0);
    note_dur = 8'd0;
    #1;
    check("reset_dur0", note_over, 1'b1);
    note_dur = 8'd8;
    rst_n    = 1'b0;

    foreach (vecs[i]) begin
      clr      = vecs[i].clr;
      en       = vecs[i].en;
      note_dur = vecs[i].dur;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), note_over, vecs[i].exp);
    end

    // Count is now 1: same-cycle response to note_dur with the counter held
    en = 1'b0;
    note_dur = 8'd1;
    #1;
    check("dur_eq_cnt_comb", note_over, 1'b1);
    note_dur = 8'd2;
    #1;
    check("dur_ne_cnt_comb", note_over, 1'b0);

    // Clear wins over enable
    clr = 1'b1;
    en  = 1'b1;
    note_dur = 8'd0;
    @(posedge clk);
    #1;
    check("clr_over_en", note_over, 1'b1);

    // Count to 5, then asynchronous reset between edges
    clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    note_dur = 8'd5;
    #1;
    check("cnt5", note_over, 1'b1);
    rst_n = 1'b1;
    #1;
    check("async_rst_dur5", note_over, 1'b0);
    note_dur = 8'd0;
    #1;
    check("async_rst_dur0", note_over, 1'b1);
    en = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_hold", note_over, 1'b1);
    en = 1'b1;
    note_dur = 8'd1;
    @(posedge clk);
    #1;
    check("post_rst_first_en", note_over, 1'b1);

    // Randomized traffic against the model; resynchronise with a reset
    rst_n = 1'b1;
    #1;
    model_cnt = 0;
    rst_n = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clr = ($urandom_range(0, 31) == 0);
      en  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       note_dur = 8'($urandom);
        1:       note_dur = 8'($urandom_range(0, 7));
        default: note_dur = 8'((model_cnt + int'($urandom_range(0, 2))) % 256);
      endcase
      #1;
      check("rand_comb", note_over, model_over());
      @(posedge clk);
      model_edge();
      #1;
      check("rand_edge", note_over, model_over());
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b1;
        model_cnt = 0;
        #1;
        check("rand_async_rst", note_over, model_over());
        rst_n = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piezo_dur_cnt.md
PIEZO_DUR_CNT -- requirements
Module: piezo_dur_cnt

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 8 bits.
REQ-002 The module SHALL have port `clk`: input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port `rst_n`: input, 1 bit, asynchronous reset, active-high (asserted = 1), despite the suffix.
REQ-004 The module SHALL have port `clr`: input, 1 bit, synchronous clear of the duration counter.
REQ-005 The module SHALL have port `en`: input, 1 bit, count enable.
REQ-006 The module SHALL have port `note_dur`: input, 8 bits, unsigned target duration in clock ticks.
REQ-007 The module SHALL have port `note_over`: output, 1 bit, high when the elapsed count equals `note_dur`.

Function
REQ-008 The module SHALL contain one internal 8-bit unsigned register `dur_cnt`, not exported.
REQ-009 `dur_cnt` update priority on each rising `clk` edge SHALL be:
- `clr`=1 -> 0.
- Else `en`=1 -> `dur_cnt`+1.
- Else hold.
REQ-010 `clr` SHALL override `en` when both are high in the same cycle.
REQ-011 Increment SHALL be modulo 256: 8'hFF + 1 wraps to 8'h00; no saturation, no auto-stop at `note_dur`.
REQ-012 `note_over` SHALL be combinational, equal to (`dur_cnt` == `note_dur`), with no extra register stage.
REQ-013 A change on `note_dur` SHALL be reflected on `note_over` in the same cycle, with no clock edge required.
REQ-014 When `dur_cnt` == `note_dur` and `en`=1, the counter SHALL keep incrementing, so `note_over` is a one-cycle-per-match indication, not a latched flag.
REQ-015 `note_dur`=0 SHALL assert `note_over` whenever `dur_cnt` is 0, including directly after reset or clear.
REQ-016 Latency SHALL be as follows:
- `note_over` rises at the edge where `dur_cnt` becomes `note_dur`.
- From a count of 0 with `en` held high, that is exactly `note_dur` rising edges.

Reset
REQ-017 While `rst_n`=1, `dur_cnt` SHALL be 0 immediately, independent of `clk`.
REQ-018 Reset assertion mid-count SHALL abort the count; `note_over` then reflects (0 == `note_dur`).
REQ-019 After `rst_n` deasserts, counting SHALL resume on the first rising edge at which `en`=1.

Verification
REQ-020 Reset with `note_dur`=8, `en`=1, then release reset -> `note_over`=0, then `note_over`=1 after exactly 8 rising edges.
REQ-021 With the count at 8, set `clr`=1 and `note_dur`=1 for one edge -> `note_over`=0 (count 0); release `clr`, next edge -> `note_over`=1.
REQ-022 With the count at 1, set `en`=0 and `note_dur`=6 for 3 edges -> `note_over` stays 0; set `en`=1, after 5 more edges -> `note_over`=1.
REQ-023 Continuing from count 6, set `note_dur`=8'hFF, `en`=1 for 249 edges -> `note_over`=1 (count 255); one further edge -> count wraps to 0 and `note_over`=0.
REQ-024 Assert `clr` and `en` together -> count 0; assert `rst_n` asynchronously between edges mid-count -> count 0 immediately.
REQ-025 Change `note_dur` to equal the current count while `en`=0 -> `note_over` goes to 1 in the same cycle.
